// File: rtl/gba_cart_host_if.sv
// Bundle of command, data and Game Pak bus signals for the cartridge bus initiator.
// The master modport is the initiator's view; slave is the environment's.
interface gba_cart_host_if;
  // Command: accepted on the edge where cmd_valid and cmd_ready are both high.
  // Write data: wdata is taken on the edge that enters a write strobe while
  // wdata_valid is high; wdata_ready pulses in the following cycle.
  // The caller holds wdata until it sees that pulse.
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        bus_nCS;
  logic        bus_nRD;
  logic        bus_nWR;
  logic        bus_nCS2;
  logic [15:0] bus_AD_out;
  logic        bus_AD_oe;
  logic [15:0] bus_AD_in;
  logic [7:0]  bus_A_out;
  logic        bus_A_oe;
  logic [2:0]  state_dbg;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, bus_AD_in,
    output cmd_ready, wdata_ready, rdata, rdata_valid, busy,
    output bus_nCS, bus_nRD, bus_nWR, bus_nCS2, bus_AD_out, bus_AD_oe,
    output bus_A_out, bus_A_oe, state_dbg
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, bus_AD_in,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, busy,
    input  bus_nCS, bus_nRD, bus_nWR, bus_nCS2, bus_AD_out, bus_AD_oe,
    input  bus_A_out, bus_A_oe, state_dbg
  );
endinterface

// File: rtl/gba_cart_host.sv
// GBA Game Pak ROM-space bus initiator: address setup and latch on nCS, then a
// burst of nRD or nWR strobes relying on the cartridge's address auto-increment.
module gba_cart_host #(
  parameter int T_SETUP = 2,
  parameter int T_LOW   = 4,
  parameter int T_HIGH  = 2
) (
  input logic clock,
  input logic reset,
  gba_cart_host_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_WDWAIT  = 3'd3;
  localparam logic [2:0] S_STROBE  = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [3:0] SETUP_LD = 4'(T_SETUP - 1);
  localparam logic [3:0] LOW_LD   = 4'(T_LOW - 1);
  localparam logic [3:0] HIGH_LD  = 4'(T_HIGH - 1);

  logic [2:0]  state;
  logic [3:0]  phase;
  logic [8:0]  beats;
  logic        wr;
  logic [15:0] ad_q;
  logic [7:0]  a_q;
  logic [15:0] rdata_q;
  logic        rvalid_q;
  logic        wready_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      phase    <= 4'd0;
      beats    <= 9'd0;
      wr       <= 1'b0;
      ad_q     <= 16'd0;
      a_q      <= 8'd0;
      rdata_q  <= 16'd0;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state <= S_SETUP;
            phase <= SETUP_LD;
            wr    <= bus.cmd_write;
            ad_q  <= bus.cmd_addr[15:0];
            a_q   <= bus.cmd_addr[23:16];
            beats <= {1'b0, bus.cmd_len} + 9'd1;
          end
        end
        S_SETUP: begin
          if (phase == 4'd0) begin
            state <= S_LATCH;
            phase <= SETUP_LD;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        S_LATCH: begin
          if (phase != 4'd0) begin
            phase <= phase - 4'd1;
          end else if (!wr) begin
            state <= S_STROBE;
            phase <= LOW_LD;
          end else if (bus.wdata_valid) begin
            state    <= S_STROBE;
            phase    <= LOW_LD;
            ad_q     <= bus.wdata;
            wready_q <= 1'b1;
          end else begin
            state <= S_WDWAIT;
          end
        end
        S_WDWAIT: begin
          if (bus.wdata_valid) begin
            state    <= S_STROBE;
            phase    <= LOW_LD;
            ad_q     <= bus.wdata;
            wready_q <= 1'b1;
          end
        end
        S_STROBE: begin
          // The read sample is taken at the end of the low phase, when the
          // cartridge has had the longest time to drive AD.
          if (phase == 4'd0) begin
            state <= S_RECOVER;
            phase <= HIGH_LD;
            beats <= beats - 9'd1;
            if (!wr) begin
              rdata_q  <= bus.bus_AD_in;
              rvalid_q <= 1'b1;
            end
          end else begin
            phase <= phase - 4'd1;
          end
        end
        S_RECOVER: begin
          if (phase != 4'd0) begin
            phase <= phase - 4'd1;
          end else if (beats == 9'd0) begin
            state <= S_DONE;
          end else if (!wr) begin
            state <= S_STROBE;
            phase <= LOW_LD;
          end else if (bus.wdata_valid) begin
            state    <= S_STROBE;
            phase    <= LOW_LD;
            ad_q     <= bus.wdata;
            wready_q <= 1'b1;
          end else begin
            state <= S_WDWAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes and enables are decoded from the registered state so they never
  // glitch and cannot fall while nCS is high.
  logic in_cs;
  assign in_cs = (state == S_LATCH) || (state == S_WDWAIT) ||
                 (state == S_STROBE) || (state == S_RECOVER);

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.bus_nCS     = !in_cs;
  assign bus.bus_nRD     = !((state == S_STROBE) && !wr);
  assign bus.bus_nWR     = !((state == S_STROBE) && wr);
  assign bus.bus_nCS2    = 1'b1;
  assign bus.bus_AD_out  = ad_q;
  assign bus.bus_A_out   = a_q;
  assign bus.bus_A_oe    = (state == S_SETUP) || in_cs;
  assign bus.bus_AD_oe   = (state == S_SETUP) || (state == S_LATCH) || (state == S_WDWAIT) ||
                           (wr && ((state == S_STROBE) || (state == S_RECOVER)));
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.wdata_ready = wready_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_gba_cart_host.sv
// Directed bench for gba_cart_host: default-timing instance on cart, all-ones
// timing instance on cart_x, each with a small responder model on AD.
module tb_gba_cart_host;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gba_cart_host_if cart();
  gba_cart_host_if cart_x();

  gba_cart_host dut (.clock(clk), .reset(rst), .bus(cart));
  gba_cart_host #(.T_SETUP(1), .T_LOW(1), .T_HIGH(1)) dut_x (.clock(clk), .reset(rst), .bus(cart_x));

  // ---------------- responder models ----------------
  int          rsp_cnt = 0;
  int          rsp_start = 0;
  logic [15:0] rsp_base = 16'h0000;
  logic        rd_prev = 1'b1;
  int          rsp_x_cnt = 0;
  logic        rd_x_prev = 1'b1;

  always @(negedge clk) begin
    if (cart.bus_nRD === 1'b1 && rd_prev === 1'b0) rsp_cnt <= rsp_cnt + 1;
    rd_prev <= cart.bus_nRD;
    if (cart_x.bus_nRD === 1'b1 && rd_x_prev === 1'b0) rsp_x_cnt <= rsp_x_cnt + 1;
    rd_x_prev <= cart_x.bus_nRD;
  end

  assign cart.bus_AD_in   = (cart.bus_nRD === 1'b0) ? rsp_base + 16'(rsp_cnt - rsp_start) : 16'h0000;
  assign cart_x.bus_AD_in = (cart_x.bus_nRD === 1'b0) ? 16'h8000 + 16'(rsp_x_cnt) : 16'h0000;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] exp_x_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int inv_err = 0;
  int x_pulses = 0, x_period_err = 0, x_last = -1, x_rd_low = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return #1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cart.rdata_valid === 1'b1) begin
      check("rdata_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rdata", 32'(cart.rdata), 32'(exp_q.pop_front()));
    end
    if (cart_x.rdata_valid === 1'b1) begin
      x_pulses++;
      if (x_last >= 0 && cyc - x_last != 2) x_period_err++;
      x_last = cyc;
      check("rdata_x_pending", 32'(exp_x_q.size() != 0), 32'd1);
      if (exp_x_q.size() != 0) check("rdata_x", 32'(cart_x.rdata), 32'(exp_x_q.pop_front()));
    end
    if (cart_x.bus_nRD === 1'b0) x_rd_low++;
    if (cart.bus_nRD === 1'b0 && cart.bus_nWR === 1'b0) inv_err++;
    if ((cart.bus_nRD === 1'b0 || cart.bus_nWR === 1'b0) && cart.bus_nCS !== 1'b0) inv_err++;
    if (cart.bus_nCS2 !== 1'b1 || cart_x.bus_nCS2 !== 1'b1) inv_err++;
    if (cart_x.bus_nRD === 1'b0 && cart_x.bus_nCS !== 1'b0) inv_err++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Returns in cycle 1 (just after the accepting edge).
  task automatic send_cmd(input logic w, input logic [23:0] a, input logic [7:0] l);
    int n;
    cart.cmd_valid = 1'b1;
    cart.cmd_write = w;
    cart.cmd_addr  = a;
    cart.cmd_len   = l;
    n = 0;
    while (cart.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cart.cmd_ready), 32'd1);
    tick();
    cart.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (cart.busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(cart.busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int cycles, pulses, low_run, high_run, bad_low, bad_high, ncs_bad, seen_low;
  int stall_hi, wr_pulses, wr_mis, ad_mis, wr_low, wd_idx;
  int accepts, first_acc, acc_gap, busy_ready, n;
  logic nwr_prev;
  logic [15:0] cur_w;

  initial begin
    cart.cmd_valid = 1'b0;  cart.cmd_write = 1'b0;  cart.cmd_addr = 24'd0;  cart.cmd_len = 8'd0;
    cart.wdata = 16'd0;     cart.wdata_valid = 1'b0;
    cart_x.cmd_valid = 1'b0; cart_x.cmd_write = 1'b0; cart_x.cmd_addr = 24'd0; cart_x.cmd_len = 8'd0;
    cart_x.wdata = 16'd0;    cart_x.wdata_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset values
    check("rst_strobes", 32'({cart.bus_nCS, cart.bus_nRD, cart.bus_nWR, cart.bus_nCS2}), 32'hF);
    check("rst_oe", 32'({cart.bus_AD_oe, cart.bus_A_oe}), 32'd0);
    check("rst_ad_out", 32'(cart.bus_AD_out), 32'd0);
    check("rst_a_out", 32'(cart.bus_A_out), 32'd0);
    check("rst_rdata", 32'(cart.rdata), 32'd0);
    check("rst_pulses", 32'({cart.rdata_valid, cart.wdata_ready, cart.busy}), 32'd0);
    check("rst_state", 32'(cart.state_dbg), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(cart.cmd_ready), 32'd1);

    // Single read, cycle-by-cycle against the reference timeline
    rsp_base = 16'hBEEF; rsp_start = rsp_cnt;
    exp_q.push_back(16'hBEEF);
    send_cmd(1'b0, 24'h123456, 8'd0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 4) begin
        check("t1_ad_out", 32'(cart.bus_AD_out), 32'h3456);
        check("t1_a_out", 32'(cart.bus_A_out), 32'h12);
      end
      check("t1_ad_oe", 32'(cart.bus_AD_oe), (c <= 4) ? 32'd1 : 32'd0);
      check("t1_ncs", 32'(cart.bus_nCS), (c >= 3 && c <= 10) ? 32'd0 : 32'd1);
      check("t1_nrd", 32'(cart.bus_nRD), (c >= 5 && c <= 8) ? 32'd0 : 32'd1);
      check("t1_rvalid", 32'(cart.rdata_valid), (c == 9) ? 32'd1 : 32'd0);
      if (c == 9) check("t1_rdata", 32'(cart.rdata), 32'hBEEF);
      check("t1_ready", 32'(cart.cmd_ready), (c == 12) ? 32'd1 : 32'd0);
      if (c < 12) tick();
    end

    // Burst read, len 3
    rsp_base = 16'h0001; rsp_start = rsp_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
    send_cmd(1'b0, 24'h000100, 8'd3);
    cycles = 1; pulses = 0; low_run = 0; high_run = 0; bad_low = 0; bad_high = 0; ncs_bad = 0; seen_low = 0;
    while (cart.busy === 1'b1 && cycles < 100) begin
      if (cart.bus_nRD === 1'b0) begin
        if (low_run == 0) begin
          pulses++;
          if (seen_low != 0 && high_run != 2) bad_high++;
        end
        low_run++; high_run = 0; seen_low = 1;
        if (cart.bus_nCS !== 1'b0) ncs_bad++;
      end else begin
        if (low_run != 0 && low_run != 4) bad_low++;
        low_run = 0; high_run++;
        if (seen_low != 0 && pulses < 4 && cart.bus_nCS !== 1'b0) ncs_bad++;
      end
      tick();
      cycles++;
    end
    check("t2_pulses", 32'(pulses), 32'd4);
    check("t2_low_len", 32'(bad_low), 32'd0);
    check("t2_high_len", 32'(bad_high), 32'd0);
    check("t2_ncs_low", 32'(ncs_bad), 32'd0);
    check("t2_duration", 32'(cycles), 32'd30);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Write len 1 with a 5-cycle data stall
    cart.wdata_valid = 1'b0; cart.wdata = 16'hA5A5;
    send_cmd(1'b1, 24'h004000, 8'd1);
    cycles = 1; stall_hi = 0; wr_pulses = 0; wr_mis = 0; ad_mis = 0; wr_low = 0; wd_idx = 0;
    nwr_prev = 1'b1; cur_w = 16'h0000;
    while (cart.busy === 1'b1 && cycles < 60) begin
      if (cycles >= 5 && cycles <= 9 && cart.bus_nWR === 1'b1 && cart.bus_nCS === 1'b0) stall_hi++;
      if (cart.wdata_ready !== (cart.bus_nWR === 1'b0 && nwr_prev === 1'b1)) wr_mis++;
      if (cart.wdata_ready === 1'b1) cur_w = cart.wdata;
      if (cart.bus_nWR === 1'b0) begin
        wr_low++;
        if (cart.bus_AD_out !== cur_w || cart.bus_AD_oe !== 1'b1) ad_mis++;
      end
      if (cart.wdata_ready === 1'b1) begin
        wr_pulses++;
        if (wd_idx == 0) begin
          cart.wdata = 16'h5A5A; wd_idx = 1;
        end else begin
          cart.wdata_valid = 1'b0;
        end
      end
      nwr_prev = cart.bus_nWR;
      if (cycles == 9) begin
        cart.wdata_valid = 1'b1; cart.wdata = 16'hA5A5;
      end
      tick();
      cycles++;
    end
    cart.wdata_valid = 1'b0;
    check("t3_stall_cycles", 32'(stall_hi), 32'd5);
    check("t3_wready_pulses", 32'(wr_pulses), 32'd2);
    check("t3_wready_vs_nwr", 32'(wr_mis), 32'd0);
    check("t3_ad_hold", 32'(ad_mis), 32'd0);
    check("t3_nwr_low", 32'(wr_low), 32'd8);
    check("t3_duration", 32'(cycles), 32'd23);

    // Reset during the 2nd strobe of a len 7 read
    rsp_base = 16'h1000; rsp_start = rsp_cnt;
    exp_q.push_back(16'h1000);
    send_cmd(1'b0, 24'h000200, 8'd7);
    repeat (10) tick();
    check("t4_in_2nd_strobe", 32'(cart.bus_nRD), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("t4_strobes", 32'({cart.bus_nCS, cart.bus_nRD, cart.bus_nWR}), 32'h7);
    check("t4_oe", 32'({cart.bus_AD_oe, cart.bus_A_oe}), 32'd0);
    check("t4_busy", 32'(cart.busy), 32'd0);
    check("t4_rvalid", 32'(cart.rdata_valid), 32'd0);
    check("t4_state", 32'(cart.state_dbg), 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t4_still_idle", 32'(cart.busy), 32'd0);

    // cmd_valid held across a whole transfer
    rsp_base = 16'h2000; rsp_start = rsp_cnt;
    exp_q.push_back(16'h2000); exp_q.push_back(16'h2001);
    cart.cmd_valid = 1'b1; cart.cmd_write = 1'b0; cart.cmd_addr = 24'h000300; cart.cmd_len = 8'd0;
    accepts = 0; first_acc = -1; acc_gap = 0; busy_ready = 0; n = 0;
    while (n < 80 && !(accepts == 2 && cart.busy === 1'b0)) begin
      if (cart.busy === 1'b1 && cart.cmd_ready === 1'b1) busy_ready++;
      if (cart.cmd_valid === 1'b1 && cart.cmd_ready === 1'b1) begin
        accepts++;
        if (accepts == 1) first_acc = n; else acc_gap = n - first_acc;
      end
      tick();
      n++;
      if (accepts == 2) cart.cmd_valid = 1'b0;
    end
    check("t5_accepts", 32'(accepts), 32'd2);
    check("t5_accept_gap", 32'(acc_gap), 32'd12);
    check("t5_ready_while_busy", 32'(busy_ready), 32'd0);
    wait_idle("t5_idle", 40);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // All-ones timing, 256-beat read
    for (int i = 0; i < 256; i++) exp_x_q.push_back(16'h8000 + 16'(i));
    x_pulses = 0; x_period_err = 0; x_last = -1; x_rd_low = 0;
    cart_x.cmd_valid = 1'b1; cart_x.cmd_write = 1'b0; cart_x.cmd_addr = 24'h000000; cart_x.cmd_len = 8'd255;
    check("t6_ready", 32'(cart_x.cmd_ready), 32'd1);
    tick();
    cart_x.cmd_valid = 1'b0;
    n = 0;
    while (cart_x.busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("t6_busy_cycles", 32'(n), 32'd515);
    check("t6_rvalid_pulses", 32'(x_pulses), 32'd256);
    check("t6_beat_period", 32'(x_period_err), 32'd0);
    check("t6_strobe_cycles", 32'(x_rd_low), 32'd256);
    check("t6_sb_empty", 32'(exp_x_q.size()), 32'd0);

    repeat (3) tick();
    check("bus_invariants", 32'(inv_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gba_cart_host.md
# gba_cart_host

Initiator side of the GBA Game Pak bus. It generates the cartridge ROM-space bus cycles that a GBA would issue: address latch on nCS, then burst nRD or nWR strobes. It sits in the FPGA fabric alongside the existing cartridge responder, behind the same IOBUF tri-state split (`*_in`, `*_out`, `*_oe`). It is used for loopback bring-up of the responder and for driving a physical cartridge from the board.

## Interface

Parameters:

- T_SETUP, 2: cycles address is driven before nCS falls, and cycles it is held after nCS falls (range 1..15).
- T_LOW, 4: cycles per strobe low phase (range 1..15).
- T_HIGH, 2: cycles per strobe high/recovery phase (range 1..15).

Ports (clock and reset first):

- clock, in, 1: single clock domain. One clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: high only in IDLE; a command is accepted on `cmd_valid & cmd_ready`.
- cmd_write, in, 1: 1 selects nWR burst, 0 selects nRD burst.
- cmd_addr, in, 24: halfword address; [15:0] goes on AD, [23:16] goes on A.
- cmd_len, in, 8: beats minus one (1..256 beats).
- wdata, in, 16: write beat data.
- wdata_valid, in, 1: write beat data is valid.
- wdata_ready, out, 1: one-cycle pulse when a write beat is consumed.
- rdata, out, 16: captured read data.
- rdata_valid, out, 1: one-cycle pulse per read beat.
- busy, out, 1: high in any state other than IDLE.
- bus_nCS, out, 1: ROM chip select, active-low.
- bus_nRD, out, 1: read strobe, active-low.
- bus_nWR, out, 1: write strobe, active-low.
- bus_nCS2, out, 1: SRAM chip select; constant 1.
- bus_AD_out, out, 16: AD drive value.
- bus_AD_oe, out, 1: AD output enable.
- bus_AD_in, in, 16: AD sampled value.
- bus_A_out, out, 8: A drive value.
- bus_A_oe, out, 1: A output enable.

## Operation

States: IDLE, SETUP, LATCH, WDWAIT, STROBE, RECOVER, DONE. A 4-bit phase counter and a 9-bit beat counter are loaded with `cmd_len + 1`.

- **IDLE**
  - nCS, nRD and nWR are 1; both oe are 0; cmd_ready is 1.
  - On accept, latch addr, len and write; go to SETUP.
- **SETUP** (T_SETUP cycles)
  - AD_out = addr[15:0], A_out = addr[23:16], both oe are 1, nCS is 1.
  - Then go to LATCH.
- **LATCH** (T_SETUP cycles)
  - nCS is 0; the address is still driven.
  - On exit, reads go to STROBE; writes go to WDWAIT if `!wdata_valid`, else STROBE.
- **WDWAIT**
  - nCS is 0, strobes are high, AD_oe is 1 holding the last driven value.
  - Go to STROBE when wdata_valid is high.
- **STROBE** (T_LOW cycles)
  - Read: nRD is 0 and AD_oe is 0 from the first STROBE cycle. On the last STROBE cycle, register `bus_AD_in` into rdata.
  - Write: nWR is 0. On STROBE entry, consume wdata (wdata_ready pulses in the first STROBE cycle); AD_out = wdata, held through STROBE and RECOVER.
- **RECOVER** (T_HIGH cycles)
  - Strobe is 1; decrement the beat counter.
  - If beats remain, go to STROBE (writes go via WDWAIT if `!wdata_valid`); otherwise go to DONE.
- **DONE** (1 cycle)
  - nCS is 1, both oe are 0; then go to IDLE.

Rules:

- The master never re-presents the address mid-burst; the cartridge auto-increments.
- A burst whose AD[15:0] would wrap past 0xFFFF is not split. Cartridge behavior in that case is the caller's responsibility.
- nRD and nWR are never low simultaneously.
- A strobe is never low while nCS is 1.

## Timing

- Reset values:
  - nCS, nRD, nWR and nCS2 are 1.
  - AD_oe and A_oe are 0.
  - AD_out, A_out and rdata are 0.
  - rdata_valid, wdata_ready and busy are 0.
  - cmd_ready is 1 in the first cycle after reset deasserts.
- Reset asserted mid-burst: all outputs take their idle values on the next edge and the state becomes IDLE. No rdata_valid or wdata_ready is produced after reset is sampled.
- rdata_valid pulses in the first RECOVER cycle of each read beat, with rdata stable until the next capture.
- Beat period is T_LOW + T_HIGH cycles plus any WDWAIT cycles.
- Single-beat read with defaults, command accepted at edge 0:
  - Cycles 1–2: SETUP.
  - Cycles 3–4: LATCH.
  - Cycles 5–8: STROBE (nRD low).
  - Cycle 9: RECOVER start, rdata_valid.
  - Cycles 9–10: RECOVER.
  - Cycle 11: DONE.
  - Cycle 12: IDLE, cmd_ready = 1.
- cmd_valid while busy is ignored. A command presented in the same cycle DONE exits is accepted in the following IDLE cycle.

## Test plan

- **Single read:** defaults, read addr 0x123456 len 0, responder model drives AD = 0xBEEF while nRD is low. Required: AD_out = 0x3456 and A_out = 0x12 in cycles 1–4; nCS falls at cycle 3; nRD low in cycles 5–8; rdata = 0xBEEF with rdata_valid in cycle 9; cmd_ready in cycle 12.
- **Burst read:** len 3, model returns 0x0001..0x0004. Required: exactly 4 nRD pulses, each 4 low / 2 high; 4 rdata_valid pulses carrying 0x0001..0x0004 in order; nCS stays low from the first nRD through the last.
- **Write with stall:** write len 1, wdata_valid low for 5 cycles after LATCH, then 0xA5A5 and 0x5A5A. Required: WDWAIT holds nWR = 1 for 5 cycles; each wdata_ready pulse coincides with nWR falling; AD carries each value for the full strobe.
- **Reset mid-burst:** assert reset during the 2nd STROBE of a len 7 read. Required: next cycle nCS, nRD and nWR are 1, both oe are 0, busy is 0; no further rdata_valid.
- **Command while busy:** hold cmd_valid during a transfer. Required: cmd_ready stays 0 until IDLE; exactly one extra command is accepted afterward; nCS2 remains 1 throughout.
- **Parameter extremes:** T_SETUP = T_LOW = T_HIGH = 1, len 255 read. Required: 256 rdata_valid pulses, beat period 2 cycles, beat counter terminates with no extra strobe.
